// File: rtl/npc_pkg.sv
// npc_pkg: shared decode constants and encodings for the D-stage next-PC unit.
//   - MIPS opcode / funct / REGIMM rt-field constants
//   - ext_mode, cmp_mode and npc_sel encodings
//   - prediction FSM state enum
package npc_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [1:0] {
    EXT_NONE = 2'b00,
    EXT_ZERO = 2'b01,
    EXT_SIGN = 2'b10,
    EXT_LUI  = 2'b11
  } ext_mode_e;

  typedef enum logic [2:0] {
    CMP_NONE = 3'b000,
    CMP_BEQ  = 3'b001,
    CMP_BNE  = 3'b010,
    CMP_BGTZ = 3'b011,
    CMP_BGEZ = 3'b100,
    CMP_BLTZ = 3'b101,
    CMP_BLEZ = 3'b110
  } cmp_mode_e;

  typedef enum logic [2:0] {
    NPC_SEQ   = 3'b000,
    NPC_BR    = 3'b001,
    NPC_J     = 3'b010,
    NPC_JR    = 3'b011,
    NPC_RAS   = 3'b100,
    NPC_REDIR = 3'b101
  } npc_sel_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } npc_state_e;

endpackage

// File: rtl/npc_ras.sv
// npc_ras: circular return-address stack.
//   push/pop/clear : update requests (clear wins, pop+push overwrites top)
//   push_data      : address pushed
//   top            : most recently pushed valid entry
//   count          : number of valid entries, saturates at DEPTH
// A push into a full stack overwrites the oldest entry (the pointer simply
// wraps); a pop on an empty stack is ignored.
module npc_ras
  #(parameter int DEPTH = 4,
    parameter int AW    = 32)
  (input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [AW-1:0]              push_data,
   output logic [AW-1:0]              top,
   output logic [$clog2(DEPTH):0]     count);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] entries_q [DEPTH];
  logic [AW-1:0] entries_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] top_idx;
  logic          do_pop;

  // ptr_q is the next free slot; the top lives one below it.
  assign top_idx = ptr_q - 1'b1;
  assign top     = entries_q[top_idx];
  assign count   = count_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
      ptr_d   = '0;
      count_d = '0;
    end else if (do_pop && push) begin
      entries_d[top_idx] = push_data;
    end else if (do_pop) begin
      ptr_d   = top_idx;
      count_d = count_q - 1'b1;
    end else if (push) begin
      entries_d[ptr_q] = push_data;
      ptr_d            = ptr_q + 1'b1;
      if (count_q != CW'(DEPTH)) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/npc_ras_unit_d.sv
// npc_ras_unit_d: decode-stage next-PC unit with return-address prediction.
//   Inputs : instr_d/pc_d/pc_f, forwarded rs_data/rt_data with rs_ready,
//            advance_d, E-stage resolve_valid/resolve_target.
//   Outputs: ext_mode, cmp_mode, br_taken, npc_sel, npc, stall_req,
//            mispredict (combinational); pred_pending, ras_count (registered);
//            state_dbg exposes the prediction FSM state.
// Optional: define RAS_STATS_EN to add saturating pred_cnt / mispred_cnt.
// A `jr $31` whose rs is not yet forwardable may proceed on the RAS top;
// the E stage later confirms it or forces a redirect and the RAS is emptied.
module npc_ras_unit_d
  import npc_pkg::*;
  #(parameter int RAS_DEPTH = 4,
    parameter int AW        = 32)
  (input  logic                         clk,
   input  logic                         reset_n,
   input  logic [31:0]                  instr_d,
   input  logic [AW-1:0]                pc_d,
   input  logic [AW-1:0]                pc_f,
   input  logic [31:0]                  rs_data,
   input  logic [31:0]                  rt_data,
   input  logic                         rs_ready,
   input  logic                         advance_d,
   input  logic                         resolve_valid,
   input  logic [AW-1:0]                resolve_target,
   output logic [1:0]                   ext_mode,
   output logic [2:0]                   cmp_mode,
   output logic [2:0]                   npc_sel,
   output logic [AW-1:0]                npc,
   output logic                         br_taken,
   output logic                         stall_req,
   output logic                         pred_pending,
   output logic                         mispredict,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
`ifdef RAS_STATS_EN
   output logic [15:0]                  pred_cnt,
   output logic [15:0]                  mispred_cnt,
`endif
   output npc_state_e                   state_dbg);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  assign op = instr_d[31:26];
  assign rs = instr_d[25:21];
  assign rt = instr_d[20:16];
  assign rd = instr_d[15:11];
  assign fn = instr_d[5:0];

  npc_state_e    state_q, state_d;
  logic [AW-1:0] pred_target_q, pred_target_d;
  logic [AW-1:0] ras_top;
  logic          is_jr, is_jalr, is_jreg, is_branch, cond, is_link, is_ret;
  logic          pred_allowed, predict, upd, pred_adv;
  cmp_mode_e     cmp;
  ext_mode_e     ext;
  npc_sel_e      sel;

  assign is_jr   = (op == OP_SPECIAL) && (fn == FN_JR);
  assign is_jalr = (op == OP_SPECIAL) && (fn == FN_JALR);
  assign is_jreg = is_jr || is_jalr;
  assign is_ret  = is_jreg && (rs == REG_RA);
  // Link instructions push even when the branch is not taken.
  assign is_link = (op == OP_JAL) ||
                   ((op == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL))) ||
                   (is_jalr && (rd == REG_RA));

  always_comb begin
    cmp = CMP_NONE;
    case (op)
      OP_BEQ:  cmp = CMP_BEQ;
      OP_BNE:  cmp = CMP_BNE;
      OP_BLEZ: cmp = CMP_BLEZ;
      OP_BGTZ: cmp = CMP_BGTZ;
      OP_REGIMM: begin
        if ((rt == RT_BLTZ) || (rt == RT_BLTZAL)) cmp = CMP_BLTZ;
        if ((rt == RT_BGEZ) || (rt == RT_BGEZAL)) cmp = CMP_BGEZ;
      end
      default: cmp = CMP_NONE;
    endcase
  end

  always_comb begin
    ext = EXT_NONE;
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: ext = EXT_SIGN;
      OP_ANDI, OP_ORI, OP_XORI:             ext = EXT_ZERO;
      OP_LUI:                               ext = EXT_LUI;
      default: if (op[5]) ext = EXT_SIGN;   // loads and stores
    endcase
  end

  assign is_branch = (cmp != CMP_NONE);

  always_comb begin
    cond = 1'b0;
    case (cmp)
      CMP_BEQ:  cond = (rs_data == rt_data);
      CMP_BNE:  cond = (rs_data != rt_data);
      CMP_BGTZ: cond = ($signed(rs_data) > 0);
      CMP_BGEZ: cond = !rs_data[31];
      CMP_BLTZ: cond = rs_data[31];
      CMP_BLEZ: cond = ($signed(rs_data) <= 0);
      default:  cond = 1'b0;
    endcase
  end

  assign br_taken = is_branch && cond;

  // A mispredict is only possible while a prediction is outstanding.
  assign mispredict = resolve_valid && (state_q == ST_PENDING) &&
                      (resolve_target != pred_target_q);

  // A matching resolve frees the single outstanding-prediction slot this cycle.
  assign pred_allowed = (ras_count != '0) &&
                        ((state_q == ST_IDLE) ||
                         (resolve_valid && (resolve_target == pred_target_q)));
  assign predict = is_jr && (rs == REG_RA) && !rs_ready && pred_allowed;

  always_comb begin
    sel = NPC_SEQ;
    npc = pc_f + AW'(4);
    if (mispredict) begin
      sel = NPC_REDIR;
      npc = resolve_target;
    end else if (br_taken) begin
      sel = NPC_BR;
      npc = pc_d + AW'(4) + {{(AW-18){instr_d[15]}}, instr_d[15:0], 2'b00};
    end else if ((op == OP_J) || (op == OP_JAL)) begin
      sel = NPC_J;
      npc = {pc_d[AW-1:28], instr_d[25:0], 2'b00};
    end else if (is_jreg && rs_ready) begin
      sel = NPC_JR;
      npc = AW'(rs_data);
    end else if (predict) begin
      sel = NPC_RAS;
      npc = ras_top;
    end
  end

  assign stall_req = (is_jreg && !rs_ready && !predict) || (is_branch && !rs_ready);
  assign ext_mode  = ext;
  assign cmp_mode  = cmp;
  assign npc_sel   = sel;

  // The D instruction is flushed on a mispredict, so it never updates state.
  assign upd      = advance_d && !mispredict;
  assign pred_adv = upd && (sel == NPC_RAS);

  npc_ras #(.DEPTH(RAS_DEPTH), .AW(AW)) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (upd && is_link),
    .pop       (upd && is_ret),
    .clear     (mispredict),
    .push_data (pc_d + AW'(8)),
    .top       (ras_top),
    .count     (ras_count)
  );

  always_comb begin
    state_d       = state_q;
    pred_target_d = pred_target_q;
    if (mispredict) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:
          if (pred_adv) begin
            state_d       = ST_PENDING;
            pred_target_d = ras_top;
          end
        ST_PENDING:
          if (resolve_valid) begin
            state_d = ST_IDLE;
            if (pred_adv) begin
              state_d       = ST_PENDING;
              pred_target_d = ras_top;
            end
          end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pred_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign pred_pending = (state_q == ST_PENDING);
  assign state_dbg    = state_q;

`ifdef RAS_STATS_EN
  logic [15:0] pred_cnt_q, pred_cnt_d, mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    pred_cnt_d    = pred_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (pred_adv && (pred_cnt_q != 16'hffff))      pred_cnt_d    = pred_cnt_q + 16'd1;
    if (mispredict && (mispred_cnt_q != 16'hffff)) mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pred_cnt_q    <= pred_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pred_cnt    = pred_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_npc_ras_unit_d.sv
// tb_npc_ras_unit_d: directed bench for npc_ras_unit_d (default build).
module tb_npc_ras_unit_d;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_d, pc_d, pc_f, rs_data, rt_data, resolve_target;
  logic        rs_ready, advance_d, resolve_valid;
  logic [1:0]  ext_mode;
  logic [2:0]  cmp_mode, npc_sel;
  logic [31:0] npc;
  logic        br_taken, stall_req, pred_pending, mispredict;
  logic [2:0]  ras_count;
  npc_state_e  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  // clock / reset
  always #5 clk = ~clk;

  npc_ras_unit_d #(.RAS_DEPTH(4), .AW(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_f           (pc_f),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .rs_ready       (rs_ready),
    .advance_d      (advance_d),
    .resolve_valid  (resolve_valid),
    .resolve_target (resolve_target),
    .ext_mode       (ext_mode),
    .cmp_mode       (cmp_mode),
    .npc_sel        (npc_sel),
    .npc            (npc),
    .br_taken       (br_taken),
    .stall_req      (stall_req),
    .pred_pending   (pred_pending),
    .mispredict     (mispredict),
    .ras_count      (ras_count),
    .state_dbg      (state_dbg)
  );

  // instruction encoders
  function automatic logic [31:0] enc_beq(input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {6'h04, s, t, imm};
  endfunction
  function automatic logic [31:0] enc_bne(input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {6'h05, s, t, imm};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [25:0] idx);
    return {6'h03, idx};
  endfunction
  function automatic logic [31:0] enc_jr(input logic [4:0] s);
    return {6'h00, s, 15'd0, 6'h08};
  endfunction
  function automatic logic [31:0] enc_bgezal(input logic [4:0] s, input logic [15:0] imm);
    return {6'h01, s, 5'h11, imm};
  endfunction
  function automatic logic [31:0] enc_itype(input logic [5:0] o);
    return {o, 5'd1, 5'd2, 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: set D-stage inputs just after an edge, let them settle
  task automatic drive(input logic [31:0] ins, input logic [31:0] pcd, input logic rdy,
                       input logic adv, input logic rv, input logic [31:0] rtgt);
    instr_d = ins; pc_d = pcd; rs_ready = rdy; advance_d = adv;
    resolve_valid = rv; resolve_target = rtgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; instr_d = '0; pc_d = '0; pc_f = 32'h100; rs_data = '0; rt_data = '0;
    rs_ready = 1'b0; advance_d = 1'b0; resolve_valid = 1'b0; resolve_target = '0;
    #12;
    check("rst_pending", 32'(pred_pending), 0);
    check("rst_count", 32'(ras_count), 0);
    check("rst_mispredict", 32'(mispredict), 0);
    check("rst_npc", npc, 32'h104);
    check("rst_sel", 32'(npc_sel), 0);
    reset_n = 1'b1;
    tick();

    // extender modes
    drive(enc_itype(6'h0f), 32'h3000, 1, 0, 0, 0);
    check("ext_lui", 32'(ext_mode), 3);
    drive(enc_itype(6'h0d), 32'h3000, 1, 0, 0, 0);
    check("ext_ori", 32'(ext_mode), 1);
    drive(enc_itype(6'h09), 32'h3000, 1, 0, 0, 0);
    check("ext_addiu", 32'(ext_mode), 2);
    check("cmp_none", 32'(cmp_mode), 0);

    // beq taken, bne not taken, branch with rs not ready
    rs_data = 32'd5; rt_data = 32'd5;
    drive(enc_beq(5'd1, 5'd2, 16'd4), 32'h3000, 1, 0, 0, 0);
    check("beq_taken", 32'(br_taken), 1);
    check("beq_sel", 32'(npc_sel), 1);
    check("beq_npc", npc, 32'h3014);
    check("beq_cmp", 32'(cmp_mode), 1);
    check("beq_stall", 32'(stall_req), 0);
    drive(enc_bne(5'd1, 5'd2, 16'd4), 32'h3000, 1, 0, 0, 0);
    check("bne_taken", 32'(br_taken), 0);
    check("bne_sel", 32'(npc_sel), 0);
    check("bne_npc", npc, 32'h104);
    check("bne_cmp", 32'(cmp_mode), 2);
    drive(enc_beq(5'd1, 5'd2, 16'hfffc), 32'h3000, 1, 0, 0, 0);
    check("beq_neg_npc", npc, 32'h2ff4);
    drive(enc_beq(5'd1, 5'd2, 16'd4), 32'h3000, 0, 0, 0, 0);
    check("beq_unready_stall", 32'(stall_req), 1);

    // jal then predicted jr $31, then matching resolve
    drive(enc_jal(26'h0000c40), 32'h3000, 1, 1, 0, 0);
    check("jal_sel", 32'(npc_sel), 2);
    check("jal_npc", npc, 32'h3100);
    tick();
    check("jal_count", 32'(ras_count), 1);
    drive(enc_jr(5'd31), 32'h3100, 0, 1, 0, 0);
    check("jr_pred_sel", 32'(npc_sel), 4);
    check("jr_pred_npc", npc, 32'h3008);
    check("jr_pred_stall", 32'(stall_req), 0);
    tick();
    check("jr_pred_pending", 32'(pred_pending), 1);
    check("jr_pred_count", 32'(ras_count), 0);
    drive(32'h0, 32'h3104, 1, 0, 1, 32'h3008);
    check("resolve_ok_misp", 32'(mispredict), 0);
    tick();
    check("resolve_ok_pending", 32'(pred_pending), 0);
    resolve_valid = 1'b0;

    // mispredict path, with stall of a second unready jr while pending
    drive(enc_jal(26'h0000800), 32'h2000, 1, 1, 0, 0);
    tick();
    drive(enc_jal(26'h0000c40), 32'h3000, 1, 1, 0, 0);
    tick();
    check("two_push_count", 32'(ras_count), 2);
    drive(enc_jr(5'd31), 32'h3100, 0, 1, 0, 0);
    check("jr2_npc", npc, 32'h3008);
    tick();
    drive(enc_jr(5'd31), 32'h3200, 0, 0, 0, 0);
    check("pend_jr_stall", 32'(stall_req), 1);
    check("pend_jr_sel", 32'(npc_sel), 0);
    tick();
    check("pend_jr_count", 32'(ras_count), 1);
    check("pend_still", 32'(pred_pending), 1);
    drive(enc_jal(26'h0000c40), 32'h3300, 1, 1, 1, 32'h4000);
    check("misp_flag", 32'(mispredict), 1);
    check("misp_sel", 32'(npc_sel), 5);
    check("misp_npc", npc, 32'h4000);
    tick();
    resolve_valid = 1'b0; advance_d = 1'b0;
    check("misp_count", 32'(ras_count), 0);
    check("misp_pending", 32'(pred_pending), 0);

    // matching resolve with a new predicted advance in the same cycle
    drive(enc_jal(26'h0001000), 32'h5000, 1, 1, 0, 0);
    tick();
    drive(enc_jal(26'h0001000), 32'h6000, 1, 1, 0, 0);
    tick();
    drive(enc_jr(5'd31), 32'h4000, 0, 1, 0, 0);
    check("chain1_npc", npc, 32'h6008);
    tick();
    drive(enc_jr(5'd31), 32'h6008, 0, 1, 1, 32'h6008);
    check("chain2_misp", 32'(mispredict), 0);
    check("chain2_sel", 32'(npc_sel), 4);
    check("chain2_npc", npc, 32'h5008);
    tick();
    check("chain2_pending", 32'(pred_pending), 1);
    check("chain2_count", 32'(ras_count), 0);
    drive(32'h0, 32'h5008, 1, 0, 1, 32'h5008);
    check("chain3_misp", 32'(mispredict), 0);
    tick();
    check("chain3_pending", 32'(pred_pending), 0);

    // asynchronous reset while a prediction is outstanding
    drive(enc_jal(26'h0001000), 32'h7000, 1, 1, 0, 0);
    tick();
    drive(enc_jr(5'd31), 32'h4000, 0, 1, 0, 0);
    tick();
    check("pre_rst_pending", 32'(pred_pending), 1);
    drive(32'h0, 32'h0, 1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pending", 32'(pred_pending), 0);
    check("async_rst_count", 32'(ras_count), 0);
    reset_n = 1'b1;
    tick();

    // overfill: five pushes into four entries, then walk the predictions
    for (int i = 0; i < 5; i++) begin
      drive(enc_jal(26'h0000100), 32'(8 + 16 * i), 1, 1, 0, 0);
      tick();
    end
    check("full_count", 32'(ras_count), 4);
    drive(enc_jr(5'd31), 32'h100, 0, 1, 0, 0);
    check("pop1_npc", npc, 32'h50);
    tick();
    drive(enc_jr(5'd31), 32'h50, 0, 1, 1, 32'h50);
    check("pop2_npc", npc, 32'h40);
    tick();
    drive(enc_jr(5'd31), 32'h40, 0, 1, 1, 32'h40);
    check("pop3_npc", npc, 32'h30);
    tick();
    drive(enc_jr(5'd31), 32'h30, 0, 1, 1, 32'h30);
    check("pop4_npc", npc, 32'h20);
    tick();
    check("empty_count", 32'(ras_count), 0);
    drive(enc_jr(5'd31), 32'h20, 0, 0, 1, 32'h20);
    check("empty_stall", 32'(stall_req), 1);
    check("empty_sel", 32'(npc_sel), 0);
    tick();
    check("empty_pending", 32'(pred_pending), 0);
    resolve_valid = 1'b0;

    // bgezal not taken still links
    rs_data = 32'hffffffff;
    drive(enc_bgezal(5'd4, 16'd8), 32'h7000, 1, 1, 0, 0);
    check("bgezal_sel", 32'(npc_sel), 0);
    check("bgezal_taken", 32'(br_taken), 0);
    check("bgezal_cmp", 32'(cmp_mode), 4);
    tick();
    check("bgezal_count", 32'(ras_count), 1);
    drive(enc_jr(5'd31), 32'h7004, 0, 0, 0, 0);
    check("bgezal_top", npc, 32'h7008);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
